wash_cycle_controller: RTL and testbench
========================================

WASH_CYCLE_CONTROLLER -- requirements
Module: wash_cycle_controller

Interface
REQ-001 SHALL have parameter TICKS_PER_SEC, default 50000000: clk cycles per one-second tick.
REQ-002 SHALL have parameters FILL_S=3, WASH_S=9, RINSE_S=6, SPIN_S=5: phase durations in seconds, each legal range 1..9.
REQ-003 SHALL have port clk, input, 1: single system clock, rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port start, input, 1: start/acknowledge request, sampled each clk.
REQ-006 SHALL have port door_closed, input, 1: 1 = door shut.
REQ-007 SHALL have port pause, input, 1: level; 1 = hold the running program.
REQ-008 SHALL have port stage, output, 3: current state code, per REQ-011.
REQ-009 SHALL have port digit, output, 4: seconds remaining in the current phase, 0..9, for a seven-segment decoder.
REQ-010 SHALL have ports door_lock, water_valve, motor, motor_fast, done, output, 1 each: actuator and status strobes, registered.

Function
REQ-011 SHALL implement FSM states IDLE=0, FILL=1, WASH=2, RINSE=3, SPIN=4, DONE=5; stage equals the state code.
REQ-012 SHALL accept start only in IDLE with door_closed=1; FILL entered on next edge, counter loaded with FILL_S, prescaler cleared.
REQ-013 SHALL, in IDLE with door_closed=0, ignore start.
REQ-014 SHALL generate sec_tick for one cycle every TICKS_PER_SEC running cycles; prescaler counts 0..TICKS_PER_SEC-1.
REQ-015 SHALL decrement the phase counter on sec_tick; on the sec_tick where counter==1, advance FILL->WASH->RINSE->SPIN->DONE, load the next duration (DONE loads 0).
REQ-016 SHALL give each phase exactly D*TICKS_PER_SEC cycles; start accept to DONE entry = (FILL_S+WASH_S+RINSE_S+SPIN_S)*TICKS_PER_SEC+1 cycles.
REQ-017 SHALL drive digit = counter in FILL..SPIN, 0 in IDLE and DONE.
REQ-018 SHALL assert door_lock in FILL..SPIN; water_valve in FILL; motor in WASH, RINSE, SPIN; motor_fast only in SPIN; done only in DONE.
REQ-019 SHALL hold (prescaler, counter, state frozen; water_valve, motor, motor_fast forced 0; door_lock kept 1) while pause=1 or door_closed=0 in FILL..SPIN; resume from frozen values when both clear.
REQ-020 SHALL ignore start in FILL..SPIN (no restart).
REQ-021 SHALL leave DONE for IDLE on start=1 or door_closed=0, whichever first; simultaneous start and door opening -> IDLE (no new cycle).
REQ-022 SHALL treat pause and door_closed as synchronous inputs already synchronised upstream.

Reset
REQ-023 SHALL, on rst_n=0, immediately force state=IDLE, counter=0, prescaler=0, all outputs 0 (stage=0, digit=0), including mid-program.
REQ-024 SHALL, after rst_n rises, require a fresh start to begin a cycle.

Structure
REQ-025 SHALL place state codes and default phase durations in a shared include file (wash_defs) used by this block and the display top.
REQ-026 SHALL implement the prescaler as sub-module sec_prescaler (inputs clk, rst_n, clear, enable; output tick).
REQ-027 SHALL keep FSM, counter and output registers in wash_cycle_controller.

Verification (TICKS_PER_SEC=4, defaults)
REQ-028 SHALL test nominal run: start pulse, door_closed=1 -> FILL with digit 3,2,1 each 4 cycles; DONE, done=1, reached 93 cycles after start accepted.
REQ-029 SHALL test door open in IDLE: door_closed=0, start=1 -> stage stays 0, all outputs 0.
REQ-030 SHALL test pause: pause=1 for 10 cycles in WASH at digit=7 -> motor=0, digit stays 7, door_lock=1; resume adds exactly 10 cycles to total.
REQ-031 SHALL test reset mid-SPIN: rst_n=0 -> same cycle stage=0, door_lock=0, motor_fast=0; no restart without start.
REQ-032 SHALL test DONE exit: start and door_closed=0 in same cycle in DONE -> IDLE, no FILL entry.
REQ-033 SHALL test start during RINSE -> ignored, phase timing unchanged.

Source files
------------

// File: rtl/wash_defs_pkg.sv
// wash_defs_pkg: shared state codes, default phase durations and phase sequencing for the wash controller and display top
package wash_defs_pkg;
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FILL  = 3'd1;
  localparam logic [2:0] ST_WASH  = 3'd2;
  localparam logic [2:0] ST_RINSE = 3'd3;
  localparam logic [2:0] ST_SPIN  = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;
  localparam int DEF_FILL_S  = 3;
  localparam int DEF_WASH_S  = 9;
  localparam int DEF_RINSE_S = 6;
  localparam int DEF_SPIN_S  = 5;
  function automatic logic [2:0] next_stage(input logic [2:0] s);
    return (s == ST_SPIN) ? ST_DONE : s + 3'd1;
  endfunction
  function automatic logic is_running(input logic [2:0] s);
    return (s >= ST_FILL) && (s <= ST_SPIN);
  endfunction
endpackage

// File: rtl/sec_prescaler.sv
// sec_prescaler: one-cycle tick every TICKS enabled cycles (clk, rst_n async low, clear, enable -> tick)
module sec_prescaler #(
  parameter int TICKS = 50000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic tick
);
  localparam int W = (TICKS > 1) ? $clog2(TICKS) : 1;
  logic [W-1:0] cnt_q, cnt_d;
  logic wrap;
  assign wrap = (cnt_q == W'(TICKS - 1));
  assign tick = enable && wrap;
  always_comb cnt_d = clear ? '0 : !enable ? cnt_q : wrap ? '0 : cnt_q + 1'b1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/wash_cycle_controller.sv
// wash_cycle_controller: timed fill/wash/rinse/spin sequencer with pause/door hold (start, door_closed, pause -> stage, digit, actuator strobes)
module wash_cycle_controller
  import wash_defs_pkg::*;
#(
  parameter int TICKS_PER_SEC = 50000000,
  parameter int FILL_S  = DEF_FILL_S,
  parameter int WASH_S  = DEF_WASH_S,
  parameter int RINSE_S = DEF_RINSE_S,
  parameter int SPIN_S  = DEF_SPIN_S
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       door_closed,
  input  logic       pause,
  output logic [2:0] stage,
  output logic [3:0] digit,
  output logic       door_lock,
  output logic       water_valve,
  output logic       motor,
  output logic       motor_fast,
  output logic       done
);
  logic [2:0] state_q, state_d, nxt;
  logic [3:0] cnt_q, cnt_d, nxt_dur;
  logic run, act, tick;
  logic lock_q, lock_d, valve_q, valve_d, motor_q, motor_d, fast_q, fast_d, done_q, done_d;
  assign run = is_running(state_q);
  assign act = door_closed && !pause;
  sec_prescaler #(.TICKS(TICKS_PER_SEC)) u_presc (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (!run),
    .enable(run && act),
    .tick  (tick)
  );
  assign nxt = next_stage(state_q);
  assign nxt_dur = (nxt == ST_WASH) ? 4'(WASH_S) : (nxt == ST_RINSE) ? 4'(RINSE_S) :
                   (nxt == ST_SPIN) ? 4'(SPIN_S) : 4'd0;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_IDLE && start && door_closed) begin
      state_d = ST_FILL;
      cnt_d   = 4'(FILL_S);
    end else if (run && tick) begin
      state_d = (cnt_q == 4'd1) ? nxt : state_q;
      cnt_d   = (cnt_q == 4'd1) ? nxt_dur : cnt_q - 4'd1;
    end else if (state_q == ST_DONE && (start || !door_closed)) begin
      state_d = ST_IDLE;
    end
    lock_d  = is_running(state_d);
    valve_d = (state_d == ST_FILL) && act;
    motor_d = (state_d >= ST_WASH) && (state_d <= ST_SPIN) && act;
    fast_d  = (state_d == ST_SPIN) && act;
    done_d  = (state_d == ST_DONE);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      lock_q  <= 1'b0;
      valve_q <= 1'b0;
      motor_q <= 1'b0;
      fast_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lock_q  <= lock_d;
      valve_q <= valve_d;
      motor_q <= motor_d;
      fast_q  <= fast_d;
      done_q  <= done_d;
    end
  assign stage       = state_q;
  assign digit       = cnt_q;
  assign door_lock   = lock_q;
  assign water_valve = valve_q;
  assign motor       = motor_q;
  assign motor_fast  = fast_q;
  assign done        = done_q;
endmodule

// File: tb/tb_wash_cycle_controller.sv
// tb_wash_cycle_controller: directed self-checking bench for the wash controller at four ticks per second
module tb_wash_cycle_controller;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, door_closed = 1'b1, pause = 1'b0;
  logic [2:0] stage;
  logic [3:0] digit;
  logic door_lock, water_valve, motor, motor_fast, done;
  int checks = 0, failures = 0, n = 0;
  wash_cycle_controller #(.TICKS_PER_SEC(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .door_closed(door_closed),
    .pause      (pause),
    .stage      (stage),
    .digit      (digit),
    .door_lock  (door_lock),
    .water_valve(water_valve),
    .motor      (motor),
    .motor_fast (motor_fast),
    .done       (done)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic run_prog(input int mode, output int cnt);
    bit hit = 0;
    cnt = 0;
    start = 1'b1;
    while (stage != 3'd5 && cnt < 400) begin
      step();
      cnt++;
      if (cnt == 1) begin
        start = 1'b0;
        check("fill_stage", stage, 1);
        check("fill_digit3", digit, 3);
        check("fill_valve", water_valve, 1);
        check("fill_lock", door_lock, 1);
      end
      if (mode == 0 && cnt == 4) check("fill_digit3_last", digit, 3);
      if (mode == 0 && cnt == 5) check("fill_digit2", digit, 2);
      if (mode == 0 && cnt == 12) check("fill_digit1", digit, 1);
      if (mode == 0 && cnt == 13) begin
        check("wash_stage", stage, 2);
        check("wash_digit9", digit, 9);
        check("wash_motor", motor, 1);
        check("wash_valve_off", water_valve, 0);
      end
      if (mode == 0 && cnt == 73) begin
        check("spin_stage", stage, 4);
        check("spin_fast", motor_fast, 1);
        check("spin_digit5", digit, 5);
      end
      if (mode == 1 && !hit && stage == 3'd2 && digit == 4'd7) begin
        hit = 1;
        pause = 1'b1;
        step();
        cnt++;
        check("pause_motor_off", motor, 0);
        repeat (9) begin
          step();
          cnt++;
        end
        check("pause_motor_held", motor, 0);
        check("pause_digit", digit, 7);
        check("pause_lock", door_lock, 1);
        check("pause_stage", stage, 2);
        pause = 1'b0;
        step();
        cnt++;
        check("resume_motor", motor, 1);
      end
      if (mode == 2 && !hit && stage == 3'd3) begin
        hit = 1;
        start = 1'b1;
        step();
        cnt++;
        start = 1'b0;
        check("rinse_start_ignored", stage, 3);
      end
    end
  endtask
  initial begin
    repeat (3) step();
    check("rst_stage", stage, 0);
    check("rst_outs", {digit, door_lock, water_valve, motor, motor_fast, done}, 0);
    rst_n = 1'b1;
    step();
    door_closed = 1'b0;
    start = 1'b1;
    repeat (3) step();
    check("open_idle_stage", stage, 0);
    check("open_idle_outs", {digit, door_lock, water_valve, motor, motor_fast, done}, 0);
    start = 1'b0;
    door_closed = 1'b1;
    step();
    run_prog(0, n);
    check("nominal_cycles", n, 93);
    check("done_flag", done, 1);
    check("done_digit", digit, 0);
    check("done_lock", door_lock, 0);
    start = 1'b1;
    door_closed = 1'b0;
    step();
    start = 1'b0;
    door_closed = 1'b1;
    check("done_exit_stage", stage, 0);
    check("done_exit_flag", done, 0);
    step();
    check("done_exit_no_fill", stage, 0);
    run_prog(1, n);
    check("pause_cycles", n, 103);
    start = 1'b1;
    step();
    start = 1'b0;
    check("done_start_exit", stage, 0);
    step();
    run_prog(2, n);
    check("rinse_start_cycles", n, 93);
    door_closed = 1'b0;
    step();
    check("done_door_exit", stage, 0);
    door_closed = 1'b1;
    step();
    n = 0;
    start = 1'b1;
    while (stage != 3'd4 && n < 200) begin
      step();
      n++;
      start = 1'b0;
    end
    check("reach_spin", stage, 4);
    step();
    rst_n = 1'b0;
    #1;
    check("midspin_rst_stage", stage, 0);
    check("midspin_rst_lock", door_lock, 0);
    check("midspin_rst_fast", motor_fast, 0);
    check("midspin_rst_digit", digit, 0);
    step();
    rst_n = 1'b1;
    repeat (10) step();
    check("no_restart", stage, 0);
    check("no_restart_lock", door_lock, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
